// File: rtl/decode_reg_file_pkg.sv
// Shared types and sizing for the decode-stage register file.
// Addresses 0-31 are integer r0-r31, 32-63 are FP f0-f31.
package decode_reg_file_pkg;

    localparam int REG_ADDR_W = 6;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 64;
    localparam int FP_BASE    = 32;

    typedef logic [REG_ADDR_W-1:0] addr_t;
    typedef logic [0:DATA_W-1]     data_t;

    localparam addr_t ZERO_REG = '0;

endpackage

// File: rtl/decode_reg_file_if.sv
// Decode-side bundle: write-back, source reads, reservation, hazard.
// master = decode/writeback side, slave = register file.
interface decode_reg_file_if;
    import decode_reg_file_pkg::*;

    logic  RegWBWE;
    addr_t RegWBAddr;
    data_t RegWBData;
    addr_t RAddrA;
    addr_t RAddrB;
    logic  SrcAUsed;
    logic  SrcBUsed;
    logic  ReserveEn;
    addr_t ReserveAddr;
    data_t RDataA;
    data_t RDataB;
    logic  Hazard;

    modport master (
        output RegWBWE, RegWBAddr, RegWBData,
        output RAddrA, RAddrB, SrcAUsed, SrcBUsed,
        output ReserveEn, ReserveAddr,
        input  RDataA, RDataB, Hazard
    );

    modport slave (
        input  RegWBWE, RegWBAddr, RegWBData,
        input  RAddrA, RAddrB, SrcAUsed, SrcBUsed,
        input  ReserveEn, ReserveAddr,
        output RDataA, RDataB, Hazard
    );

endinterface

// File: rtl/decode_reg_file_scoreboard.sv
// Busy-bit scoreboard: RAW/WAW hazard detect, reserve on issue,
// release on write-back. A same-cycle write-back hides the busy bit.
module reg_scoreboard
    import decode_reg_file_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  a_used_i,
    input  addr_t a_addr_i,
    input  logic  b_used_i,
    input  addr_t b_addr_i,
    input  logic  set_en_i,
    input  addr_t set_addr_i,
    input  logic  clr_en_i,
    input  addr_t clr_addr_i,
    output logic  hazard_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                a_busy;
    logic                b_busy;
    logic                w_busy;

    function automatic logic pending(
        input logic [NUM_REGS-1:0] busy,
        input addr_t               a,
        input logic                clr,
        input addr_t               clr_a
    );
        return busy[a] && !(clr && clr_a == a);
    endfunction

    assign a_busy   = pending(busy_q, a_addr_i, clr_en_i, clr_addr_i);
    assign b_busy   = pending(busy_q, b_addr_i, clr_en_i, clr_addr_i);
    assign w_busy   = pending(busy_q, set_addr_i, clr_en_i, clr_addr_i);
    assign hazard_o = (a_used_i && a_busy)
                    || (b_used_i && b_busy)
                    || (set_en_i && w_busy);

    // Set is applied after clear so a same-address reservation wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
        if (set_en_i && !hazard_o && set_addr_i != ZERO_REG)
            busy_d[set_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

endmodule

// File: rtl/decode_reg_file.sv
// 64x32 integer/FP register file with write-before-read bypass
// and a busy-bit scoreboard that raises Hazard to stall decode.
module decode_reg_file
    import decode_reg_file_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    decode_reg_file_if.slave rf
);

    data_t regs_q [NUM_REGS];
    logic  wr_en;

    assign wr_en = rf.RegWBWE && rf.RegWBAddr != ZERO_REG;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[rf.RegWBAddr] <= rf.RegWBData;
        end
    end

    function automatic data_t rd(
        input data_t q,
        input addr_t a,
        input logic  we,
        input addr_t wa,
        input data_t wd
    );
        if (we && wa == a)   return wd;
        if (a == ZERO_REG)   return '0;
        return q;
    endfunction

    assign rf.RDataA = rd(regs_q[rf.RAddrA], rf.RAddrA,
                          wr_en, rf.RegWBAddr, rf.RegWBData);
    assign rf.RDataB = rd(regs_q[rf.RAddrB], rf.RAddrB,
                          wr_en, rf.RegWBAddr, rf.RegWBData);

    reg_scoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .a_used_i   (rf.SrcAUsed),
        .a_addr_i   (rf.RAddrA),
        .b_used_i   (rf.SrcBUsed),
        .b_addr_i   (rf.RAddrB),
        .set_en_i   (rf.ReserveEn),
        .set_addr_i (rf.ReserveAddr),
        .clr_en_i   (rf.RegWBWE),
        .clr_addr_i (rf.RegWBAddr),
        .hazard_o   (rf.Hazard)
    );

endmodule

// File: tb/tb_decode_reg_file.sv
// Bench for decode_reg_file: directed scenarios then random traffic
// against an array-based reference model.
module tb_decode_reg_file;
    import decode_reg_file_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    data_t mdl_mem  [NUM_REGS];
    bit    mdl_busy [NUM_REGS];

    decode_reg_file_if bus ();

    decode_reg_file dut (
        .clk   (clk),
        .reset (reset),
        .rf    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle();
        bus.RegWBWE     = 0;
        bus.RegWBAddr   = '0;
        bus.RegWBData   = '0;
        bus.RAddrA      = '0;
        bus.RAddrB      = '0;
        bus.SrcAUsed    = 0;
        bus.SrcBUsed    = 0;
        bus.ReserveEn   = 0;
        bus.ReserveAddr = '0;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < NUM_REGS; i++) begin
            mdl_mem[i]  = '0;
            mdl_busy[i] = 0;
        end
    endtask

    function automatic bit still_busy(input addr_t a);
        if (bus.RegWBWE && bus.RegWBAddr == a) return 0;
        return mdl_busy[a];
    endfunction

    function automatic data_t exp_rd(input addr_t a);
        if (bus.RegWBWE && bus.RegWBAddr != 0 && bus.RegWBAddr == a)
            return bus.RegWBData;
        return (a == 0) ? data_t'(0) : mdl_mem[a];
    endfunction

    function automatic bit exp_haz();
        return (bus.SrcAUsed && still_busy(bus.RAddrA))
            || (bus.SrcBUsed && still_busy(bus.RAddrB))
            || (bus.ReserveEn && still_busy(bus.ReserveAddr));
    endfunction

    // Called just after a negedge with inputs applied.
    task automatic cycle();
        bit h;
        #1;
        h = exp_haz();
        chk("rdata_a", bus.RDataA, exp_rd(bus.RAddrA));
        chk("rdata_b", bus.RDataB, exp_rd(bus.RAddrB));
        chk("hazard", {31'b0, bus.Hazard}, {31'b0, h});
        @(posedge clk);
        if (!reset) begin
            if (bus.RegWBWE && bus.RegWBAddr != 0)
                mdl_mem[bus.RegWBAddr] = bus.RegWBData;
            if (bus.RegWBWE) mdl_busy[bus.RegWBAddr] = 0;
            if (bus.ReserveEn && !h && bus.ReserveAddr != 0)
                mdl_busy[bus.ReserveAddr] = 1;
        end
        @(negedge clk);
    endtask

    // Probe busy[a] through Hazard without disturbing state.
    task automatic probe_busy(input string tag, input addr_t a,
                              input bit exp);
        idle();
        bus.SrcAUsed = 1;
        bus.RAddrA   = a;
        #1;
        chk(tag, {31'b0, bus.Hazard}, {31'b0, exp});
    endtask

    function automatic addr_t pick();
        int r = $urandom_range(0, 9);
        return (r < 8) ? addr_t'(r) : addr_t'(FP_BASE + r - 8);
    endfunction

    initial begin
        idle();
        mdl_clear();
        reset = 1;
        #1;
        chk("reset_rda", bus.RDataA, 32'h0);
        chk("reset_haz", {31'b0, bus.Hazard}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;

        // write then read, r0 write ignored
        idle();
        bus.RegWBWE = 1; bus.RegWBAddr = 5; bus.RegWBData = 32'hDEADBEEF;
        cycle();
        idle(); bus.RAddrA = 5; #1;
        chk("r5_read", bus.RDataA, 32'hDEADBEEF);
        cycle();
        idle();
        bus.RegWBWE = 1; bus.RegWBAddr = 0; bus.RegWBData = 32'h12345678;
        cycle();
        idle(); #1;
        chk("r0_read", bus.RDataA, 32'h0);
        cycle();

        // same-cycle bypass on an FP register
        idle();
        bus.RegWBWE = 1; bus.RegWBAddr = 40; bus.RegWBData = 32'hCAFEF00D;
        bus.RAddrB = 40; #1;
        chk("bypass_b", bus.RDataB, 32'hCAFEF00D);
        cycle();

        // RAW hazard and release
        idle(); bus.ReserveEn = 1; bus.ReserveAddr = 7;
        cycle();
        probe_busy("raw_haz", 7, 1);
        cycle();
        bus.RegWBWE = 1; bus.RegWBAddr = 7; bus.RegWBData = 32'h77; #1;
        chk("raw_release", {31'b0, bus.Hazard}, 32'h0);
        chk("raw_bypass", bus.RDataA, 32'h77);
        cycle();
        probe_busy("busy7_clr", 7, 0);
        cycle();

        // WAW stall, then set-wins
        idle(); bus.ReserveEn = 1; bus.ReserveAddr = 9;
        cycle();
        idle(); bus.ReserveEn = 1; bus.ReserveAddr = 9; #1;
        chk("waw_haz", {31'b0, bus.Hazard}, 32'h1);
        cycle();
        bus.RegWBWE = 1; bus.RegWBAddr = 9; bus.RegWBData = 32'h99; #1;
        chk("set_wins_haz", {31'b0, bus.Hazard}, 32'h0);
        cycle();
        probe_busy("busy9_set", 9, 1);
        cycle();
        idle(); bus.RegWBWE = 1; bus.RegWBAddr = 9;
        cycle();

        // reset mid-operation discards pending updates
        idle();
        bus.ReserveEn = 1; bus.ReserveAddr = 3;
        bus.RegWBWE = 1; bus.RegWBAddr = 12; bus.RegWBData = 32'h55;
        #2;
        reset = 1;
        idle();
        bus.RAddrA = 5; bus.RAddrB = 40; #1;
        chk("rst_rda", bus.RDataA, 32'h0);
        chk("rst_rdb", bus.RDataB, 32'h0);
        chk("rst_haz", {31'b0, bus.Hazard}, 32'h0);
        mdl_clear();
        @(negedge clk);
        reset = 0;
        probe_busy("busy3_clr", 3, 0);
        bus.RAddrB = 12; #1;
        chk("r12_dropped", bus.RDataB, 32'h0);
        cycle();

        // r0 is never reserved
        idle(); bus.ReserveEn = 1; bus.ReserveAddr = 0;
        cycle();
        probe_busy("busy0", 0, 0);
        cycle();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            bus.RegWBWE     = ($urandom_range(0, 9) < 4);
            bus.RegWBAddr   = pick();
            bus.RegWBData   = $urandom;
            bus.RAddrA      = pick();
            bus.RAddrB      = pick();
            bus.SrcAUsed    = $urandom_range(0, 1);
            bus.SrcBUsed    = $urandom_range(0, 1);
            bus.ReserveEn   = ($urandom_range(0, 9) < 4);
            bus.ReserveAddr = pick();
            if ($urandom_range(0, 199) == 0) begin
                #2;
                reset = 1;
                mdl_clear();
                idle();
                cycle();
                reset = 0;
            end else begin
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_reg_file.md
DECODE_REG_FILE -- requirements
Module: decode_reg_file

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 RegWBWE  in  1  write-back write enable.
REQ-004 RegWBAddr  in  6  write-back destination: 0-31 integer r0-r31, 32-63 FP f0-f31.
REQ-005 RegWBData  in  32  write-back data, bit 0 = MSB.
REQ-006 RAddrA, RAddrB  in  6 each  decode-stage source register addresses.
REQ-007 SrcAUsed, SrcBUsed  in  1 each  the instruction in decode actually reads source A/B.
REQ-008 ReserveEn  in  1  the instruction in decode writes a destination register.
REQ-009 ReserveAddr  in  6  destination register of the instruction in decode.
REQ-010 RDataA, RDataB  out  32 each  read data for RAddrA/RAddrB.
REQ-011 Hazard  out  1  decode must stall this cycle.

Function
REQ-012 Storage SHALL be 64 x 32-bit registers; address 0 (r0) SHALL always read 0, and writes to it SHALL be ignored.
REQ-013 A write SHALL occur on the rising edge when RegWBWE=1 and RegWBAddr!=0.
REQ-014 Reads SHALL be combinational; if RegWBWE=1, RegWBAddr!=0 and RegWBAddr equals a read address, that port SHALL return RegWBData (write-before-read bypass).
REQ-015 A scoreboard SHALL keep one busy bit per register; busy[0] SHALL be constantly 0.
REQ-016 Hazard SHALL be 1 when any of the following is true: (SrcAUsed and busy[RAddrA]), (SrcBUsed and busy[RAddrB]), or (ReserveEn and busy[ReserveAddr]) (the last is the WAW check).
REQ-017 A busy register SHALL count as not busy for REQ-016 when, in the same cycle, RegWBWE=1 and RegWBAddr equals it; data then comes through the REQ-014 bypass.
REQ-018 When ReserveEn=1, Hazard=0 and ReserveAddr!=0, busy[ReserveAddr] SHALL be set on the rising edge.
REQ-019 When RegWBWE=1, busy[RegWBAddr] SHALL be cleared on the rising edge.
REQ-020 If a set and a clear target the same address in one cycle, the set SHALL win and busy SHALL stay 1.
REQ-021 If ReserveEn=1 and Hazard=1, the reservation SHALL be dropped; decode re-presents it next cycle.
REQ-022 A write-back to a non-busy register SHALL update data and leave busy at 0.
REQ-023 Hazard SHALL depend only on current inputs and busy state, with no added register stage.

Reset
REQ-024 Asserting reset SHALL immediately clear all 64 registers and all busy bits, so RDataA=RDataB=0 and Hazard=0 with the default inputs.
REQ-025 Reset asserted mid-operation SHALL discard any write or reservation in the same cycle.
REQ-026 After reset deasserts, the first rising edge SHALL perform normal updates.

Structure
REQ-027 The shared package SHALL hold REG_ADDR_W=6, DATA_W=32, NUM_REGS=64, FP_BASE=32 and ZERO_REG=0.
REQ-028 The scoreboard SHALL be a separate sub-module named reg_scoreboard (busy array, set/clear logic, hazard compare), instantiated inside decode_reg_file.

Verification
REQ-029 Reset, then write 0xDEADBEEF to addr 5, then read A=5 next cycle -> RDataA=0xDEADBEEF; write 0x12345678 to addr 0, then read A=0 -> 0x00000000.
REQ-030 Same cycle: WE=1, WAddr=40, WData=0xCAFEF00D, RAddrB=40 -> RDataB=0xCAFEF00D in that cycle (bypass).
REQ-031 Reserve addr 7, then next cycle SrcAUsed=1 with RAddrA=7 -> Hazard=1; a cycle with WE=1, WAddr=7 -> Hazard=0 that cycle, and busy[7]=0 afterwards.
REQ-032 busy[9]=1 and ReserveEn=1, ReserveAddr=9 -> Hazard=1 and no reservation; in the same cycle as WE to 9 with ReserveEn on 9 -> Hazard=0 and busy[9]=1 after the edge (set wins).
REQ-033 Reserve addr 3 and write 0x55 to addr 12, then assert reset mid-cycle -> all reads 0, Hazard=0, and busy[3]=0 after reset is released.
REQ-034 ReserveEn=1, ReserveAddr=0, then SrcAUsed=1 with RAddrA=0 -> Hazard=0 always.
